// File: rtl/nibble_seq_adder_if.sv
// rtl/nibble_seq_adder_if.sv - operand/result handshake bundle for nibble_seq_adder
interface nibble_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/nibble_seq_adder.sv
// rtl/nibble_seq_adder.sv - WIDTH-bit add/sub built from one 4-bit slice reused N times
// One nibble per clock, LSB first; carry is registered between passes.
module nibble_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   nibble_seq_adder_if.slave bus
);
   localparam int N   = WIDTH / 4;
   localparam int K_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [K_W-1:0]   k;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [4:0]       slice;

   // The only adder in the block: a 4-bit ripple fed by the selected nibble.
   always_comb begin
      a_nib = a_reg[{k, 2'b00} +: 4];
      b_nib = b_reg[{k, 2'b00} +: 4];
      slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         k             <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
                  a_reg        <= bus.a;
                  b_reg        <= bus.sub ? ~bus.b : bus.b;
                  carry_reg    <= bus.sub | bus.cin;
                  k            <= '0;
                  in_ready_reg <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               sum_reg[{k, 2'b00} +: 4] <= slice[3:0];
               carry_reg                <= slice[4];
               if (k == K_LAST) begin
                  cout_reg      <= slice[4];
                  ovf_reg       <= (a_nib[3] == b_nib[3]) && (slice[3] != a_nib[3]);
                  out_valid_reg <= 1'b1;
                  state         <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
   assign bus.ovf       = ovf_reg;
endmodule

// File: doc/nibble_seq_adder.md
# nibble_seq_adder

Multi-cycle wide adder/subtractor that time-multiplexes a single 4-bit ripple-carry slice across a WIDTH-bit operand. It processes one nibble per clock, least significant first, with a registered carry between passes. It trades latency for area in datapaths where a full-width adder is not justified. Operands enter and results leave through valid/ready handshakes, so the block drops into streaming pipelines.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8; N = WIDTH/4 slice passes.

- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add mode.
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1, cin ignored).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the top slice (in sub mode, 1 means no borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready: latch a, b (inverted if sub), sub, and carry0 = sub ? 1 : cin; clear slice index k; go to RUN.
  - RUN: each cycle, the slice adds a[4k+3:4k] + b'[4k+3:4k] + carry_reg. The 4 sum bits are written to sum_reg[4k+3:4k] and the slice carry to carry_reg, then k increments. After the pass with k = N−1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- ovf is computed at the final pass: (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]).
- Operand inputs are captured once at acceptance. Later changes on a/b/cin/sub have no effect.
- in_valid is ignored outside IDLE.
- sum/cout/ovf are registered.
  - sum bits update nibble-by-nibble during RUN and are only meaningful while out_valid=1.
  - Values hold after the output transfer until the next operation's first pass.
- Reset (asynchronous, any state including mid-RUN):
  - State goes to IDLE and k to 0.
  - sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 after deassertion.
  - Any partial result is discarded. No output handshake occurs for the aborted operation.

## Timing
- Acceptance edge E0 → RUN occupies the cycles ending at edges E1..EN → out_valid rises after EN. Latency is N cycles (4 for WIDTH=16).
- out_valid stays high, with sum/cout/ovf stable, until the edge where out_ready=1.
- in_ready rises the cycle after the output transfer. There is no same-cycle turnaround.
- Minimum initiation interval is N+2 cycles, reached when out_ready is held high.
- out_ready high while out_valid is low has no effect.
- in_valid and out_ready may be held high continuously. Each result still transfers exactly once.
- Combinational path per cycle is one 4-bit ripple chain plus carry register setup. There is no WIDTH-long ripple.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FFF, cin=0, sub=0 → sum=0x2233, cout=0, ovf=0. out_valid asserts exactly 4 cycles after the acceptance edge.
- Full-width carry propagation: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Subtract and overflow:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
  - a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, ovf=1.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout=1.
- Backpressure and input isolation:
  - Hold out_ready=0 for 3 cycles after out_valid. sum/cout/ovf must stay stable and in_ready must stay 0.
  - Toggle a/b and pulse in_valid during RUN/DONE. The result is unchanged and there is no second acceptance.
- Back-to-back with out_ready tied high and in_valid held: two operations (0x0001+0x0001 → 0x0002, then 0x00F0+0x0010 → 0x0100) complete with an N+2 = 6 cycle spacing between acceptances.
- Reset mid-RUN: assert rst asynchronously at pass k=2.
  - Outputs go to 0 and in_ready goes to 1 immediately after deassertion; there is no out_valid pulse.
  - A following 0x1111+0x2222 yields 0x3333 with no carry contamination.
